// File: rtl/clink_serial_cc_ctrl_if.sv
// Register-bridge bundle for the CLINK serial / camera-control engine.
// master drives strobes and addresses; slave returns read data.
interface clink_serial_cc_ctrl_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  reg_wr_en;
  logic [ADDR_WIDTH-1:0] reg_wr_addr;
  logic [31:0]           reg_wr_data;
  logic                  reg_rd_en;
  logic [ADDR_WIDTH-1:0] reg_rd_addr;
  logic [31:0]           reg_rd_data;
  logic                  reg_rd_valid;

  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data,
    output reg_rd_en, reg_rd_addr,
    input  reg_rd_data, reg_rd_valid
  );

  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data,
    input  reg_rd_en, reg_rd_addr,
    output reg_rd_data, reg_rd_valid
  );
endinterface

// File: rtl/clink_serial_cc_ctrl.sv
// Camera Link SerTC/SerTFG UART with FIFOs plus CC line control.
// Optional CC pulse mode is enabled by defining CLINK_CC_PULSE_EN.
module clink_serial_cc_ctrl #(
  parameter int ADDR_WIDTH       = 7,
  parameter int FIFO_DEPTH       = 16,
  parameter int CC_WIDTH         = 4,
  parameter int BAUD_DIV_DEFAULT = 10417
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  clink_serial_cc_ctrl_if.slave bus,
  input  logic                clink_locked,
  input  logic                ser_tfg,
  output logic                ser_tc,
  output logic [CC_WIDTH-1:0] cc,
  output logic                irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [ADDR_WIDTH-1:0] A_DATA = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] A_CC   = ADDR_WIDTH'(32'h10);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(32'h20);
  localparam logic [ADDR_WIDTH-1:0] A_LOCK = ADDR_WIDTH'(32'h30);
  localparam logic [ADDR_WIDTH-1:0] A_BAUD = ADDR_WIDTH'(32'h40);
`ifdef CLINK_CC_PULSE_EN
  localparam logic [ADDR_WIDTH-1:0] A_PLEN = ADDR_WIDTH'(32'h50);
`endif

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_st_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_st_t;

  logic        wr_data, wr_cc, wr_stat, wr_baud;
  logic        rd_data_hit;
  logic [31:0] wd;

  assign wd      = bus.reg_wr_data;
  assign wr_data = bus.reg_wr_en && bus.reg_wr_addr == A_DATA;
  assign wr_cc   = bus.reg_wr_en && bus.reg_wr_addr == A_CC;
  assign wr_stat = bus.reg_wr_en && bus.reg_wr_addr == A_STAT;
  assign wr_baud = bus.reg_wr_en && bus.reg_wr_addr == A_BAUD;
  assign rd_data_hit =
    bus.reg_rd_en && bus.reg_rd_addr == A_DATA;

  logic [1:0] tfg_sync, lock_sync;
  logic       rx_in, lock;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      tfg_sync  <= 2'b11;
      lock_sync <= 2'b00;
    end else begin
      tfg_sync  <= {tfg_sync[0], ser_tfg};
      lock_sync <= {lock_sync[0], clink_locked};
    end
  end

  assign rx_in = tfg_sync[1];
  assign lock  = lock_sync[1];

  logic [15:0] baud_div;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      baud_div <= 16'(BAUD_DIV_DEFAULT);
    end else if (wr_baud) begin
      baud_div <= (wd[15:0] < 16'd16) ? 16'd16 : wd[15:0];
    end
  end

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_push, tx_pop;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_pop, rx_push_ok, rx_ovf_set;

  assign tx_full = tx_cnt == CW'(FIFO_DEPTH);
  assign tx_push = wr_data && !tx_full;
  assign rx_full = rx_cnt == CW'(FIFO_DEPTH);
  assign rx_pop  = rd_data_hit && rx_cnt != '0;

  tx_st_t      tx_st;
  logic [15:0] tx_div, tx_bcnt;
  logic [7:0]  tx_sh;
  logic [2:0]  tx_bit;
  logic        tx_last, tx_busy;

  assign tx_last = tx_bcnt == tx_div - 16'd1;
  assign tx_busy = tx_st != TX_IDLE;
  // Reloading in the last stop cycle keeps back-to-back frames gapless.
  assign tx_pop  = tx_cnt != '0 &&
    (tx_st == TX_IDLE || (tx_st == TX_STOP && tx_last));

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      tx_st   <= TX_IDLE;
      ser_tc  <= 1'b1;
      tx_div  <= 16'(BAUD_DIV_DEFAULT);
      tx_bcnt <= '0;
      tx_sh   <= '0;
      tx_bit  <= '0;
    end else begin
      unique case (tx_st)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_st   <= TX_START;
            ser_tc  <= 1'b0;
            tx_sh   <= tx_mem[tx_rp];
            tx_div  <= baud_div;
            tx_bcnt <= '0;
          end
        end
        TX_START: begin
          if (tx_last) begin
            tx_st   <= TX_DATA;
            ser_tc  <= tx_sh[0];
            tx_bcnt <= '0;
            tx_bit  <= '0;
          end else begin
            tx_bcnt <= tx_bcnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_last) begin
            tx_bcnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_st  <= TX_STOP;
              ser_tc <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx_sh  <= {1'b0, tx_sh[7:1]};
              ser_tc <= tx_sh[1];
            end
          end else begin
            tx_bcnt <= tx_bcnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_last) begin
            tx_bcnt <= '0;
            if (tx_pop) begin
              tx_st  <= TX_START;
              ser_tc <= 1'b0;
              tx_sh  <= tx_mem[tx_rp];
              tx_div <= baud_div;
            end else begin
              tx_st <= TX_IDLE;
            end
          end else begin
            tx_bcnt <= tx_bcnt + 16'd1;
          end
        end
      endcase
    end
  end

  rx_st_t      rx_st;
  logic [15:0] rx_div, rx_bcnt;
  logic [7:0]  rx_sh;
  logic [2:0]  rx_bit;
  logic        rx_prev, rx_vld, rx_ferr;
  logic        rx_hit_half, rx_hit_full;

  assign rx_hit_half = rx_bcnt == (rx_div >> 1) - 16'd1;
  assign rx_hit_full = rx_bcnt == rx_div - 16'd1;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rx_st   <= RX_IDLE;
      rx_prev <= 1'b1;
      rx_div  <= 16'(BAUD_DIV_DEFAULT);
      rx_bcnt <= '0;
      rx_sh   <= '0;
      rx_bit  <= '0;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_prev <= rx_in;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      unique case (rx_st)
        RX_IDLE: begin
          if (rx_prev && !rx_in) begin
            rx_st   <= RX_START;
            rx_div  <= baud_div;
            rx_bcnt <= '0;
          end
        end
        RX_START: begin
          if (rx_hit_half) begin
            rx_bcnt <= '0;
            rx_bit  <= '0;
            rx_st   <= rx_in ? RX_IDLE : RX_DATA;
          end else begin
            rx_bcnt <= rx_bcnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_hit_full) begin
            rx_bcnt <= '0;
            rx_sh   <= {rx_in, rx_sh[7:1]};
            rx_bit  <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_bcnt <= rx_bcnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_hit_full) begin
            rx_bcnt <= '0;
            rx_vld  <= rx_in;
            rx_ferr <= !rx_in;
            rx_st   <= rx_in ? RX_IDLE : RX_WAIT;
          end else begin
            rx_bcnt <= rx_bcnt + 16'd1;
          end
        end
        RX_WAIT: begin
          if (rx_in) rx_st <= RX_IDLE;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_push_ok = rx_vld && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_vld && rx_full && !rx_pop;

  always_ff @(posedge s_axi_aclk) begin
    if (tx_push)    tx_mem[tx_wp] <= wd[7:0];
    if (rx_push_ok) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: ;
      endcase
      if (rx_push_ok) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)     rx_rp <= rx_rp + AW'(1);
      unique case ({rx_push_ok, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  logic rx_ovf, tx_ovf, frame_err;

  // Set terms are ORed last so a same-cycle W1C loses.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_ovf    <= (rx_ovf & ~(wr_stat & wd[3])) | rx_ovf_set;
      tx_ovf    <= (tx_ovf & ~(wr_stat & wd[4])) |
                   (wr_data & tx_full);
      frame_err <= (frame_err & ~(wr_stat & wd[5])) | rx_ferr;
    end
  end

  assign irq = (rx_cnt != '0) | rx_ovf | tx_ovf | frame_err;

`ifdef CLINK_CC_PULSE_EN
  logic        wr_plen, pulse_act;
  logic [15:0] pulse_len, pulse_cnt;

  assign wr_plen = bus.reg_wr_en && bus.reg_wr_addr == A_PLEN;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cc        <= '0;
      pulse_len <= '0;
      pulse_cnt <= '0;
      pulse_act <= 1'b0;
    end else begin
      if (wr_plen) pulse_len <= wd[15:0];
      if (wr_cc && wd[31]) begin
        cc        <= (pulse_act ? cc : '0) | wd[CC_WIDTH-1:0];
        pulse_cnt <= pulse_len;
        pulse_act <= 1'b1;
      end else if (wr_cc) begin
        cc        <= wd[CC_WIDTH-1:0];
        pulse_act <= 1'b0;
      end else if (pulse_act) begin
        if (pulse_cnt == '0) begin
          cc        <= '0;
          pulse_act <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt - 16'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cc <= '0;
    end else if (wr_cc) begin
      cc <= wd[CC_WIDTH-1:0];
    end
  end
`endif

  logic [31:0] rd_next;

  always_comb begin
    rd_next = '0;
    unique case (1'b1)
      (bus.reg_rd_addr == A_DATA):
        rd_next = (rx_cnt != '0) ?
          {23'b0, 1'b1, rx_mem[rx_rp]} : '0;
      (bus.reg_rd_addr == A_CC):
        rd_next = 32'(cc);
      (bus.reg_rd_addr == A_STAT):
        rd_next = {8'b0, 8'(tx_cnt), 8'(rx_cnt),
                   2'b0, frame_err, tx_ovf, rx_ovf,
                   tx_busy, tx_full, rx_cnt != '0};
      (bus.reg_rd_addr == A_LOCK):
        rd_next = {31'b0, lock};
      (bus.reg_rd_addr == A_BAUD):
        rd_next = {16'b0, baud_div};
`ifdef CLINK_CC_PULSE_EN
      (bus.reg_rd_addr == A_PLEN):
        rd_next = {16'b0, pulse_len};
`endif
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      bus.reg_rd_data  <= '0;
      bus.reg_rd_valid <= 1'b0;
    end else begin
      bus.reg_rd_valid <= bus.reg_rd_en;
      if (bus.reg_rd_en) bus.reg_rd_data <= rd_next;
    end
  end
endmodule

// File: tb/tb_clink_serial_cc_ctrl.sv
// Randomised self-checking bench for clink_serial_cc_ctrl.
// Serial frames are modelled as bit lists; FIFOs as queues.
module tb_clink_serial_cc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clink_locked = 1'b0;
  logic       ser_tfg = 1'b1;
  logic       ser_tc, irq;
  logic [3:0] cc;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned tb_div = 10417;

  clink_serial_cc_ctrl_if #(.ADDR_WIDTH(7)) bus ();

  clink_serial_cc_ctrl #(
    .ADDR_WIDTH(7), .FIFO_DEPTH(16),
    .CC_WIDTH(4), .BAUD_DIV_DEFAULT(10417)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .bus(bus),
    .clink_locked(clink_locked),
    .ser_tfg(ser_tfg),
    .ser_tc(ser_tc),
    .cc(cc),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    int unsigned t;
    bit          ok;
  } frame_t;

  frame_t     txq[$];
  logic [7:0] rxq[$];
  bit         rxo_m = 0, txo_m = 0, fe_m = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // Watches ser_tc every cycle; each bit must be flat for tb_div clocks.
  initial begin : tx_mon
    frame_t      f;
    logic [9:0]  bits;
    int unsigned d;
    forever begin
      @(negedge clk);
      if (rst_n && ser_tc === 1'b0) begin
        d = tb_div;
        f.t = cyc;
        f.ok = 1'b1;
        bits = '0;
        for (int j = 0; j < 10; j++) begin
          for (int k = 0; k < int'(d); k++) begin
            if (j != 0 || k != 0) @(negedge clk);
            if (k == 0) bits[j] = ser_tc;
            else if (ser_tc !== bits[j]) f.ok = 1'b0;
          end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) f.ok = 1'b0;
        f.b = bits[8:1];
        txq.push_back(f);
      end
    end
  end

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.reg_wr_en   = 1'b1;
    bus.reg_wr_addr = a;
    bus.reg_wr_data = d;
    @(negedge clk);
    bus.reg_wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a,
                        input logic [31:0] e);
    @(negedge clk);
    bus.reg_rd_en   = 1'b1;
    bus.reg_rd_addr = a;
    @(negedge clk);
    bus.reg_rd_en   = 1'b0;
    check({tag, "_vld"}, {31'b0, bus.reg_rd_valid}, 32'd1);
    check(tag, bus.reg_rd_data, e);
  endtask

  task automatic set_div(input int unsigned d);
    wr(7'h40, d);
    tb_div = (d < 16) ? 16 : d;
  endtask

  function automatic logic [31:0] stat_exp(input int tx_n,
                                           input bit busy);
    return {8'd0, 8'(tx_n), 8'(rxq.size()), 2'b0,
            fe_m, txo_m, rxo_m, busy, tx_n == 16,
            rxq.size() != 0};
  endfunction

  task automatic tx_expect(input string tag, input logic [7:0] e,
                           output int unsigned t);
    int unsigned n = 0;
    frame_t f;
    t = 0;
    while (txq.size() == 0 && n < 12 * tb_div + 200) begin
      @(negedge clk);
      n++;
    end
    if (txq.size() == 0) begin
      check({tag, "_timeout"}, txq.size(), 1);
    end else begin
      f = txq.pop_front();
      t = f.t;
      check(tag, f.b, e);
      check({tag, "_fmt"}, f.ok, 1);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      ser_tfg = fr[j];
      repeat (tb_div - 1) @(negedge clk);
    end
    @(negedge clk);
    ser_tfg = 1'b1;
    repeat (4) @(negedge clk);
    if (!stop) fe_m = 1;
    else if (rxq.size() == 16) rxo_m = 1;
    else rxq.push_back(b);
  endtask

  task automatic drain_rx(input string tag);
    logic [7:0] e;
    while (rxq.size() != 0) begin
      e = rxq.pop_front();
      rd_chk(tag, 7'h00, {23'b0, 1'b1, e});
    end
  endtask

  initial begin : main
    int unsigned t0, t1, n;
    logic [7:0]  b, b0;
    logic [7:0]  txb[$];
    bus.reg_wr_en = 0;
    bus.reg_wr_addr = '0;
    bus.reg_wr_data = '0;
    bus.reg_rd_en = 0;
    bus.reg_rd_addr = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ser_tc", ser_tc, 1);
    check("rst_cc", cc, 0);
    check("rst_irq", irq, 0);
    check("rst_rd_vld", bus.reg_rd_valid, 0);
    check("rst_rd_data", bus.reg_rd_data, 0);
    rd_chk("rst_status", 7'h20, 0);
    rd_chk("rst_baud", 7'h40, 10417);
    rd_chk("rst_lock", 7'h30, 0);
    rd_chk("unmapped", 7'h7C, 0);
    rd_chk("rx_empty", 7'h00, 0);
    @(negedge clk);
    check("rd_vld_drop", bus.reg_rd_valid, 0);

    clink_locked = 1'b1;
    rd_chk("lock_1clk", 7'h30, 0);
    rd_chk("lock_2clk", 7'h30, 1);

    set_div(5);
    rd_chk("baud_clamp", 7'h40, 16);
    set_div(16);
    rd_chk("baud_16", 7'h40, 16);

    wr(7'h00, 32'hA5);
    wr(7'h00, 32'h3C);
    tx_expect("tx_a5", 8'hA5, t0);
    tx_expect("tx_3c", 8'h3C, t1);
    check("tx_b2b_gap", t1 - t0, 160);
    rd_chk("tx_idle_stat", 7'h20, stat_exp(0, 0));
    check("tx_idle_line", ser_tc, 1);

    for (int i = 0; i < 4; i++) begin
      set_div($urandom_range(40, 16));
      b = 8'($urandom);
      wr(7'h00, {24'b0, b});
      tx_expect("tx_rand", b, t0);
    end
    set_div(16);

    send_rx(8'h5A, 1'b1);
    rd_chk("rx_stat", 7'h20, stat_exp(0, 0));
    check("rx_irq", irq, 1);
    drain_rx("rx_5a");
    rd_chk("rx_stat_empty", 7'h20, stat_exp(0, 0));
    check("rx_irq_clr", irq, 0);

    for (int i = 0; i < 5; i++) send_rx(8'($urandom), 1'b1);
    rd_chk("rx_rand_stat", 7'h20, stat_exp(0, 0));
    drain_rx("rx_rand");

    @(negedge clk);
    ser_tfg = 1'b0;
    repeat (4) @(negedge clk);
    ser_tfg = 1'b1;
    repeat (200) @(negedge clk);
    rd_chk("rx_glitch", 7'h20, stat_exp(0, 0));

    send_rx(8'($urandom), 1'b0);
    rd_chk("ferr_stat", 7'h20, stat_exp(0, 0));
    check("ferr_irq", irq, 1);
    wr(7'h20, 32'h20);
    fe_m = 0;
    rd_chk("ferr_w1c", 7'h20, stat_exp(0, 0));
    check("ferr_irq_clr", irq, 0);

    b0 = 8'($urandom);
    wr(7'h00, {24'b0, b0});
    repeat (2) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (txb.size() < 16) txb.push_back(b);
      else txo_m = 1;
      wr(7'h00, {24'b0, b});
    end
    rd_chk("tx_ovf_stat", 7'h20, stat_exp(txb.size(), 1));
    check("tx_ovf_irq", irq, 1);
    tx_expect("tx_ovf_first", b0, t0);
    while (txb.size() != 0) tx_expect("tx_ovf_q", txb.pop_front(), t0);
    check("tx_ovf_count", txq.size(), 0);
    wr(7'h20, 32'h10);
    txo_m = 0;
    rd_chk("tx_ovf_w1c", 7'h20, stat_exp(0, 0));

    for (int i = 0; i < 17; i++) send_rx(8'($urandom), 1'b1);
    rd_chk("rx_ovf_stat", 7'h20, stat_exp(0, 0));
    drain_rx("rx_ovf_q");
    rd_chk("rx_ovf_drained", 7'h20, stat_exp(0, 0));
    wr(7'h20, 32'h08);
    rxo_m = 0;
    rd_chk("rx_ovf_w1c", 7'h20, stat_exp(0, 0));
    check("irq_final", irq, 0);

    wr(7'h10, 32'h3);
    check("cc_level", cc, 4'h3);
    rd_chk("cc_rd", 7'h10, 3);
    wr(7'h10, 32'hFA);
    check("cc_trunc", cc, 4'hA);
`ifdef CLINK_CC_PULSE_EN
    wr(7'h50, 32'd9);
    rd_chk("plen_rd", 7'h50, 9);
    wr(7'h10, 32'h8000_0005);
    n = 0;
    while (cc === 4'h5 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("pulse_width", n, 10);
    check("pulse_end", cc, 0);
    wr(7'h10, 32'h3);
    repeat (20) @(negedge clk);
    check("pulse_then_level", cc, 4'h3);
`else
    wr(7'h50, 32'd9);
    rd_chk("plen_absent", 7'h50, 0);
    wr(7'h10, 32'h8000_0005);
    repeat (20) @(negedge clk);
    check("bit31_ignored", cc, 4'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
